border_collision_ctrl: RTL and testbench

Multi-ball, frame-aware border collision controller for the billiard table. It sits in the hit-controller path, between the per-pixel drawing-request muxes and each ball's velocity register. For every ball channel it turns pixel-level overlap with the table border into exactly one velocity reflection per contact. Reflection happens only on axes that point into the wall, with optional energy damping and a frame-counted hold-off that prevents re-triggering while the ball is still overlapping.

---
 rtl/border_collision_pkg.sv | 25 ++
 rtl/border_collision_channel.sv | 112 +++++++++++
 rtl/border_collision_ctrl.sv | 64 ++++++
 tb/tb_border_collision_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/border_collision_pkg.sv
// Shared types and helpers for the border collision controller: channel FSM
// states, contact-count width and the damped, saturating reflection.
package border_collision_pkg;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    HIT      = 2'd1,
    LOCKED   = 2'd2,
    COOLDOWN = 2'd3
  } coll_state_t;

  localparam int COLL_CNT_W = 8;

  // A zero shift means "no damping". Negating the most negative value
  // saturates to the most positive value.
  function automatic int reflect_vel(input int v, input int shift, input int w);
    int d;
    int lim;
    lim = 1 <<< (w - 1);
    d   = (shift == 0) ? v : v - (v >>> shift);
    if (d == -lim) return lim - 1;
    return -d;
  endfunction

endpackage

// File: rtl/border_collision_channel.sv
// One ball channel: contact FSM, frame-counted hold-off, axis selection,
// registered velocity output and a saturating contact counter.
module border_collision_channel
  import border_collision_pkg::*;
#(
  parameter int POS_W          = 11,
  parameter int VEL_W          = 11,
  parameter int TOP_OFFSET     = 0,
  parameter int DOWN_OFFSET    = 479,
  parameter int LEFT_OFFSET    = 0,
  parameter int RIGHT_OFFSET   = 639,
  parameter int DAMP_SHIFT     = 0,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    bordersDR,
  input  logic                    ballDR,
  input  logic signed [POS_W-1:0] posX,
  input  logic signed [POS_W-1:0] posY,
  input  logic signed [VEL_W-1:0] velX,
  input  logic signed [VEL_W-1:0] velY,
  output logic signed [VEL_W-1:0] velXOut,
  output logic signed [VEL_W-1:0] velYOut,
  output logic                    collisionOccurred,
  output logic [COLL_CNT_W-1:0]   collisionCount,
  output coll_state_t             state
);

  localparam int HOLD_W = $clog2(HOLDOFF_FRAMES + 2);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_FRAMES);

  coll_state_t state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic hit, accept;
  logic velx_neg, velx_pos, vely_neg, vely_pos;
  logic reflect_x, reflect_y;
  logic signed [VEL_W-1:0] velx_d, vely_d;
  int rx, ry;

  assign hit    = ballDR && bordersDR;
  assign accept = (state_q == ARMED) && hit;

  // Sign bits avoid any signed/unsigned mixing against literal zero.
  assign velx_neg = velX[VEL_W-1];
  assign velx_pos = !velX[VEL_W-1] && (velX != '0);
  assign vely_neg = velY[VEL_W-1];
  assign vely_pos = !velY[VEL_W-1] && (velY != '0);

  assign reflect_x = ((int'(posX) <= LEFT_OFFSET) && velx_neg) ||
                     ((int'(posX) >= RIGHT_OFFSET) && velx_pos);
  assign reflect_y = ((int'(posY) <= TOP_OFFSET) && vely_neg) ||
                     ((int'(posY) >= DOWN_OFFSET) && vely_pos);

  always_comb begin
    rx     = reflect_vel(int'(velX), DAMP_SHIFT, VEL_W);
    ry     = reflect_vel(int'(velY), DAMP_SHIFT, VEL_W);
    velx_d = velX;
    vely_d = velY;
    if (accept && reflect_x) velx_d = rx[VEL_W-1:0];
    if (accept && reflect_y) vely_d = ry[VEL_W-1:0];
  end

  // A frame pulse seen while in HIT is intentionally dropped.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ARMED:  if (hit) state_d = HIT;
      HIT:    state_d = LOCKED;
      LOCKED: begin
        if (startOfFrame) begin
          if (HOLDOFF_FRAMES == 0) begin
            state_d = ARMED;
          end else begin
            state_d = COOLDOWN;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          if (hold_q <= HOLD_W'(1)) state_d = ARMED;
          else                      hold_d  = hold_q - 1'b1;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ARMED;
      hold_q            <= '0;
      velXOut           <= '0;
      velYOut           <= '0;
      collisionOccurred <= 1'b0;
      collisionCount    <= '0;
    end else begin
      state_q           <= state_d;
      hold_q            <= hold_d;
      velXOut           <= velx_d;
      velYOut           <= vely_d;
      collisionOccurred <= accept;
      if (accept && (collisionCount != '1)) collisionCount <= collisionCount + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/border_collision_ctrl.sv
// Multi-ball border collision controller: one independent channel per ball,
// with packed per-ball buses sliced in and out. channelState exposes each FSM.
module border_collision_ctrl
  import border_collision_pkg::*;
#(
  parameter int N_BALLS        = 4,
  parameter int POS_W          = 11,
  parameter int VEL_W          = 11,
  parameter int TOP_OFFSET     = 0,
  parameter int DOWN_OFFSET    = 479,
  parameter int LEFT_OFFSET    = 0,
  parameter int RIGHT_OFFSET   = 639,
  parameter int DAMP_SHIFT     = 0,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 startOfFrame,
  input  logic                                 bordersDR,
  input  logic [N_BALLS-1:0]                   ballDR,
  input  logic signed [N_BALLS*POS_W-1:0]      ballTopLeftPosX,
  input  logic signed [N_BALLS*POS_W-1:0]      ballTopLeftPosY,
  input  logic signed [N_BALLS*VEL_W-1:0]      ballVelX,
  input  logic signed [N_BALLS*VEL_W-1:0]      ballVelY,
  output logic signed [N_BALLS*VEL_W-1:0]      ballVelXOut,
  output logic signed [N_BALLS*VEL_W-1:0]      ballVelYOut,
  output logic [N_BALLS-1:0]                   collisionOccurred,
  output logic [N_BALLS*COLL_CNT_W-1:0]        collisionCount,
  output logic [N_BALLS*2-1:0]                 channelState
);

  for (genvar i = 0; i < N_BALLS; i++) begin : g_chan
    coll_state_t st;

    border_collision_channel #(
      .POS_W          (POS_W),
      .VEL_W          (VEL_W),
      .TOP_OFFSET     (TOP_OFFSET),
      .DOWN_OFFSET    (DOWN_OFFSET),
      .LEFT_OFFSET    (LEFT_OFFSET),
      .RIGHT_OFFSET   (RIGHT_OFFSET),
      .DAMP_SHIFT     (DAMP_SHIFT),
      .HOLDOFF_FRAMES (HOLDOFF_FRAMES)
    ) u_chan (
      .clk               (clk),
      .reset             (reset),
      .startOfFrame      (startOfFrame),
      .bordersDR         (bordersDR),
      .ballDR            (ballDR[i]),
      .posX              (ballTopLeftPosX[i*POS_W +: POS_W]),
      .posY              (ballTopLeftPosY[i*POS_W +: POS_W]),
      .velX              (ballVelX[i*VEL_W +: VEL_W]),
      .velY              (ballVelY[i*VEL_W +: VEL_W]),
      .velXOut           (ballVelXOut[i*VEL_W +: VEL_W]),
      .velYOut           (ballVelYOut[i*VEL_W +: VEL_W]),
      .collisionOccurred (collisionOccurred[i]),
      .collisionCount    (collisionCount[i*COLL_CNT_W +: COLL_CNT_W]),
      .state             (st)
    );

    assign channelState[i*2 +: 2] = st;
  end

endmodule

// File: tb/tb_border_collision_ctrl.sv
// Bench for border_collision_ctrl: directed contacts on an undamped and a
// damped instance, with pulse outputs checked against an expected queue.
module tb_border_collision_ctrl;
  import border_collision_pkg::*;

  localparam int NB = 4;
  localparam int PW = 11;
  localparam int VW = 11;
  localparam int CW = COLL_CNT_W;
  localparam int W  = 1 + 2 + VW + VW + CW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startOfFrame = 1'b0;
  logic bordersDR = 1'b0;
  logic [NB-1:0] ballDR0 = '0;
  logic [NB-1:0] ballDR1 = '0;
  logic [NB*PW-1:0] posX, posY;
  logic [NB*VW-1:0] velX, velY;

  logic [NB*VW-1:0] vxo0, vyo0, vxo1, vyo1;
  logic [NB-1:0]    occ0, occ1;
  logic [NB*CW-1:0] cnt0, cnt1;
  logic [NB*2-1:0]  st0, st1;

  logic [W-1:0] exp_q[$];
  int cmp_count  = 0;
  int fail_count = 0;
  int pulse_seen = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  border_collision_ctrl #(.DAMP_SHIFT(0), .HOLDOFF_FRAMES(2)) dut0 (
    .clk               (clk),
    .reset             (reset),
    .startOfFrame      (startOfFrame),
    .bordersDR         (bordersDR),
    .ballDR            (ballDR0),
    .ballTopLeftPosX   (posX),
    .ballTopLeftPosY   (posY),
    .ballVelX          (velX),
    .ballVelY          (velY),
    .ballVelXOut       (vxo0),
    .ballVelYOut       (vyo0),
    .collisionOccurred (occ0),
    .collisionCount    (cnt0),
    .channelState      (st0)
  );

  border_collision_ctrl #(.DAMP_SHIFT(2), .HOLDOFF_FRAMES(2)) dut1 (
    .clk               (clk),
    .reset             (reset),
    .startOfFrame      (startOfFrame),
    .bordersDR         (bordersDR),
    .ballDR            (ballDR1),
    .ballTopLeftPosX   (posX),
    .ballTopLeftPosY   (posY),
    .ballVelX          (velX),
    .ballVelY          (velY),
    .ballVelXOut       (vxo1),
    .ballVelYOut       (vyo1),
    .collisionOccurred (occ1),
    .collisionCount    (cnt1),
    .channelState      (st1)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ball(input int i, input int px, input int py, input int vx, input int vy);
    posX[i*PW +: PW] = PW'(px);
    posY[i*PW +: PW] = PW'(py);
    velX[i*VW +: VW] = VW'(vx);
    velY[i*VW +: VW] = VW'(vy);
  endtask

  task automatic push(input int d, input int ch, input int vx, input int vy, input int cnt);
    exp_q.push_back({1'(d), 2'(ch), VW'(vx), VW'(vy), CW'(cnt)});
  endtask

  task automatic clear_hits;
    ballDR0      = '0;
    ballDR1      = '0;
    bordersDR    = 1'b0;
    startOfFrame = 1'b0;
  endtask

  task automatic do_reset;
    clear_hits();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    cmp_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic signed [63:0] vx0(input int i);
    return 64'($signed(vxo0[i*VW +: VW]));
  endfunction

  function automatic logic signed [63:0] c0(input int i);
    return 64'(cnt0[i*CW +: CW]);
  endfunction

  function automatic logic signed [63:0] s0(input int i);
    return 64'(st0[i*2 +: 2]);
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    logic         pulse;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NB; i++) begin
        pulse = (d == 0) ? occ0[i] : occ1[i];
        if (pulse === 1'b1) begin
          if (d == 0) pulse_seen++;
          got = (d == 0) ? {1'b0, 2'(i), vxo0[i*VW +: VW], vyo0[i*VW +: VW], cnt0[i*CW +: CW]}
                         : {1'b1, 2'(i), vxo1[i*VW +: VW], vyo1[i*VW +: VW], cnt1[i*CW +: CW]};
          cmp_count++;
          if (exp_q.size() == 0) begin
            fail_count++;
            $display("FAIL unexpected_pulse: dut%0d ball%0d vx=%0d vy=%0d cnt=%0d, required no pulse",
                     d, i, $signed(got[VW+VW+CW-1 -: VW]), $signed(got[VW+CW-1 -: VW]), got[CW-1:0]);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              fail_count++;
              $display("FAIL pulse_dut%0d_ball%0d: got ch=%0d vx=%0d vy=%0d cnt=%0d, required ch=%0d vx=%0d vy=%0d cnt=%0d",
                       d, i, got[W-2 -: 2], $signed(got[VW+VW+CW-1 -: VW]), $signed(got[VW+CW-1 -: VW]),
                       got[CW-1:0], exp[W-2 -: 2], $signed(exp[VW+VW+CW-1 -: VW]),
                       $signed(exp[VW+CW-1 -: VW]), exp[CW-1:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NB; i++) set_ball(i, 100, 100, 0, 0);

    // Reset state
    tick(2);
    @(negedge clk);
    check("rst_velx", 64'(vxo0), 0);
    check("rst_vely", 64'(vyo0), 0);
    check("rst_occ",  64'(occ0), 0);
    check("rst_cnt",  64'(cnt0), 0);
    check("rst_state", 64'(st0), 0);
    tick(1);
    reset = 1'b0;

    // Left wall reflection, held contact gives a single pulse
    set_ball(0, 0, 100, -5, 3);
    push(0, 0, 5, 3, 1);
    ballDR0[0] = 1'b1;
    bordersDR  = 1'b1;
    tick(20);
    clear_hits();
    @(negedge clk);
    check("left_count", c0(0), 1);
    check("left_passthru", vx0(0), -5);
    tick(1);
    set_ball(0, 0, 100, 17, 3);
    @(negedge clk);
    check("latency_old", vx0(0), -5);
    tick(1);
    @(negedge clk);
    check("latency_new", vx0(0), 17);

    // Outward velocity at right wall: accepted, no reflection
    do_reset();
    set_ball(1, 639, 100, -4, 2);
    push(0, 1, -4, 2, 1);
    ballDR0[1] = 1'b1;
    bordersDR  = 1'b1;
    tick(3);
    clear_hits();
    tick(2);
    @(negedge clk);
    check("outward_locked", s0(1), int'(LOCKED));
    check("outward_count", c0(1), 1);

    // Corner contact on the damped instance
    do_reset();
    set_ball(0, 0, 0, -8, -12);
    push(1, 0, 6, 9, 1);
    ballDR1[0] = 1'b1;
    bordersDR  = 1'b1;
    tick(3);
    clear_hits();
    tick(2);

    // Hold-off across four frames with continuous contact
    do_reset();
    set_ball(2, 0, 100, -7, 1);
    pulse_seen = 0;
    push(0, 2, 7, 1, 1);
    push(0, 2, 7, 1, 2);
    ballDR0[2] = 1'b1;
    bordersDR  = 1'b1;
    tick(5);
    repeat (4) begin
      startOfFrame = 1'b1;
      tick(1);
      startOfFrame = 1'b0;
      tick(5);
    end
    clear_hits();
    tick(2);
    @(negedge clk);
    check("holdoff_pulses", 64'(pulse_seen), 2);
    check("holdoff_count", c0(2), 2);

    // Saturation, then reset while LOCKED
    do_reset();
    set_ball(3, 0, 100, -1024, 0);
    push(0, 3, 1023, 0, 1);
    ballDR0[3] = 1'b1;
    bordersDR  = 1'b1;
    tick(3);
    clear_hits();
    @(negedge clk);
    check("sat_locked", s0(3), int'(LOCKED));
    tick(1);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    check("midrst_velx", 64'(vxo0), 0);
    check("midrst_vely", 64'(vyo0), 0);
    check("midrst_occ",  64'(occ0), 0);
    check("midrst_cnt",  64'(cnt0), 0);
    check("midrst_state", 64'(st0), 0);
    tick(1);
    reset = 1'b0;
    push(0, 3, 1023, 0, 1);
    ballDR0[3] = 1'b1;
    bordersDR  = 1'b1;
    tick(1);
    clear_hits();
    tick(2);

    // Parallel hits on balls 0 and 3 coinciding with a frame pulse
    do_reset();
    set_ball(0, 0, 100, -5, 3);
    set_ball(3, 0, 100, -9, -2);
    push(0, 0, 5, 3, 1);
    push(0, 3, 9, -2, 1);
    ballDR0      = 4'b1001;
    bordersDR    = 1'b1;
    startOfFrame = 1'b1;
    tick(1);
    clear_hits();
    tick(2);
    @(negedge clk);
    check("par_locked0", s0(0), int'(LOCKED));
    check("par_locked3", s0(3), int'(LOCKED));

    // ---------------- final report ----------------
    tick(3);
    check("missing_pulses", 64'(exp_q.size()), 0);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      $display("  never seen: dut%0d ball%0d vx=%0d vy=%0d cnt=%0d", e[W-1], e[W-2 -: 2],
               $signed(e[VW+VW+CW-1 -: VW]), $signed(e[VW+CW-1 -: VW]), e[CW-1:0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
